// File: rtl/score_tracker.sv
// Timed game round controller: edge-detects start/hit/miss, runs a fixed-length
// round driven by a prescaled tick, and keeps a saturating score for the display.
module score_tracker #(
  parameter int TICK_DIV     = 100_000_000,
  parameter int GAME_SECONDS = 30,
  parameter int SCORE_MAX    = 49,
  parameter int HIT_POINTS   = 1,
  parameter int MISS_PENALTY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       hit,
  input  logic       miss,
  output logic [7:0] score,
  output logic [7:0] time_left,
  output logic       busy,
  output logic       done
);

  localparam int            TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [7:0]    score_q, score_d;
  logic [7:0]    time_q, time_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          start_p_q, start_p_d;
  logic          hit_p_q, hit_p_d;
  logic          miss_p_q, miss_p_d;

  logic start_e, hit_e, miss_e;
  logic tick_wrap, round_end;
  int   score_sum;

  assign start_e   = start & ~start_p_q;
  assign hit_e     = hit   & ~hit_p_q;
  assign miss_e    = miss  & ~miss_p_q;
  assign tick_wrap = (tick_q == TICK_LAST);
  assign round_end = tick_wrap && (time_q == 8'd1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_e)   state_d = RUN;
      RUN:     if (round_end) state_d = DONE;
      DONE:    if (start_e)   state_d = RUN;
      default:                state_d = IDLE;
    endcase
  end

  // Outputs and datapath next values
  always_comb begin
    tick_d    = tick_q;
    score_d   = score_q;
    time_d    = time_q;
    start_p_d = start;
    hit_p_d   = hit;
    miss_p_d  = miss;
    // Wide signed sum so a penalty below zero or a bonus past 255 cannot wrap.
    score_sum = int'(score_q) + (hit_e ? HIT_POINTS : 0) - (miss_e ? MISS_PENALTY : 0);

    case (state_q)
      RUN: begin
        tick_d = tick_wrap ? '0 : tick_q + 1'b1;
        if (tick_wrap) time_d = time_q - 8'd1;
        if (score_sum < 0)              score_d = 8'd0;
        else if (score_sum > SCORE_MAX) score_d = 8'(SCORE_MAX);
        else                            score_d = 8'(score_sum);
      end
      default: begin
        if (start_e) begin
          score_d = 8'd0;
          time_d  = 8'(GAME_SECONDS);
          tick_d  = '0;
        end
      end
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q    <= '0;
      score_q   <= 8'd0;
      time_q    <= 8'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      start_p_q <= 1'b0;
      hit_p_q   <= 1'b0;
      miss_p_q  <= 1'b0;
    end else begin
      tick_q    <= tick_d;
      score_q   <= score_d;
      time_q    <= time_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      start_p_q <= start_p_d;
      hit_p_q   <= hit_p_d;
      miss_p_q  <= miss_p_d;
    end
  end

  assign score     = score_q;
  assign time_left = time_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_score_tracker.sv
// Bench for score_tracker: a round-level reference model pushes the expected
// outputs for every clock edge; a negedge monitor pops and compares them.
module tb_score_tracker;

  localparam int TD = 16;
  localparam int GS = 30;
  localparam int SM = 49;

  logic       clk = 1'b0;
  logic       rst, start, hit, miss;
  logic [7:0] score, time_left;
  logic       busy, done;

  int vecs = 0;
  int errs = 0;

  score_tracker #(
    .TICK_DIV(TD), .GAME_SECONDS(GS), .SCORE_MAX(SM), .HIT_POINTS(1), .MISS_PENALTY(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .hit(hit), .miss(miss),
    .score(score), .time_left(time_left), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] score;
    logic [7:0] tl;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: round time is derived from the edge index of the start
  // edge, not from any counter mirroring the design.
  int  m_cyc = 0, m_start = 0, m_score = 0, m_tl = 0;
  bit  m_running = 0, m_finished = 0;
  bit  m_ps = 0, m_ph = 0, m_pm = 0;

  always @(posedge clk) begin
    bit se, he, me;
    int elapsed, sum;
    exp_t e;
    m_cyc++;
    if (rst) begin
      m_running = 0; m_finished = 0; m_score = 0; m_tl = 0;
      m_ps = 0; m_ph = 0; m_pm = 0;
    end else begin
      se = start && !m_ps;
      he = hit && !m_ph;
      me = miss && !m_pm;
      if (m_running) begin
        sum = m_score + (he ? 1 : 0) - (me ? 1 : 0);
        m_score = (sum < 0) ? 0 : (sum > SM) ? SM : sum;
        elapsed = m_cyc - m_start;
        m_tl = GS - elapsed / TD;
        if (elapsed == GS * TD) begin
          m_running = 0; m_finished = 1; m_tl = 0;
        end
      end else if (se) begin
        m_running = 1; m_finished = 0; m_score = 0; m_start = m_cyc; m_tl = GS;
      end
      m_ps = start; m_ph = hit; m_pm = miss;
    end
    e.score = 8'(m_score);
    e.tl    = 8'(m_tl);
    e.busy  = m_running;
    e.done  = m_finished;
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vecs++;
      if (score !== e.score || time_left !== e.tl || busy !== e.busy || done !== e.done) begin
        errs++;
        $display("FAIL scoreboard t=%0t: got score=%0d tl=%0d busy=%b done=%b, expected score=%0d tl=%0d busy=%b done=%b",
                 $time, score, time_left, busy, done, e.score, e.tl, e.busy, e.done);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int expv);
    vecs++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic cyc_in(input logic s, input logic h, input logic m);
    start = s; hit = h; miss = m;
    @(posedge clk); #1;
  endtask

  task automatic pulses(input int n, input logic h, input logic m);
    repeat (n) begin
      cyc_in(1'b0, h, m);
      cyc_in(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic wait_done;
    int n;
    n = 0;
    while (done !== 1'b1 && n < 1000) begin
      cyc_in(1'b0, 1'b0, 1'b0);
      n++;
    end
    chk("wait_done_timeout", int'(done), 1);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b1; hit = 1'b1; miss = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_score", int'(score), 0);
    chk("rst_tl",    int'(time_left), 0);
    chk("rst_busy",  int'(busy), 0);
    chk("rst_done",  int'(done), 0);

    // start held through reset release counts as an edge
    rst = 1'b0;
    cyc_in(1'b1, 1'b0, 1'b0);
    chk("rel_busy", int'(busy), 1);
    chk("rel_tl",   int'(time_left), GS);
    cyc_in(1'b0, 1'b0, 1'b0);

    pulses(12, 1'b1, 1'b0);
    chk("hit12_score", int'(score), 12);
    chk("hit12_digit", int'(score) / 5, 2);
    repeat (10) cyc_in(1'b0, 1'b1, 1'b0);
    cyc_in(1'b0, 1'b0, 1'b0);
    chk("held_hit_once", int'(score), 13);

    // start during RUN at edge s+37: ignored, time_left = 30 - 37/16
    cyc_in(1'b1, 1'b0, 1'b0);
    chk("run_start_score", int'(score), 13);
    chk("run_start_tl",    int'(time_left), 28);
    chk("run_start_busy",  int'(busy), 1);
    cyc_in(1'b0, 1'b0, 1'b0);

    pulses(60, 1'b1, 1'b0);
    chk("sat_max", int'(score), SM);
    pulses(55, 1'b0, 1'b1);
    chk("floor_zero", int'(score), 0);
    pulses(5, 1'b1, 1'b0);
    pulses(1, 1'b1, 1'b1);
    chk("hit_miss_net", int'(score), 5);
    pulses(2, 1'b1, 1'b0);

    wait_done;
    chk("done_busy",  int'(busy), 0);
    chk("done_tl",    int'(time_left), 0);
    chk("done_score", int'(score), 7);
    pulses(1, 1'b1, 1'b0);
    chk("done_hit_ignored", int'(score), 7);

    cyc_in(1'b1, 1'b0, 1'b0);
    chk("restart_score", int'(score), 0);
    chk("restart_done",  int'(done), 0);
    chk("restart_busy",  int'(busy), 1);
    chk("restart_tl",    int'(time_left), GS);
    repeat (15) cyc_in(1'b0, 1'b0, 1'b0);
    chk("tl_before_tick", int'(time_left), GS);
    cyc_in(1'b0, 1'b0, 1'b0);
    chk("tl_first_tick", int'(time_left), GS - 1);
    repeat (16) cyc_in(1'b0, 1'b0, 1'b0);
    chk("tl_second_tick", int'(time_left), GS - 2);

    repeat (300)
      cyc_in(($urandom % 40) == 0, ($urandom % 3) == 0, ($urandom % 4) == 0);

    cyc_in(1'b0, 1'b0, 1'b0);
    wait_done;
    cyc_in(1'b1, 1'b0, 1'b0);
    cyc_in(1'b0, 1'b0, 1'b0);
    pulses(20, 1'b1, 1'b0);
    chk("pre_rst_score", int'(score), 20);
    n = 0;
    while (time_left !== 8'd2 && n < 600) begin
      cyc_in(1'b0, 1'b0, 1'b0);
      n++;
    end
    chk("reach_tl2", int'(time_left), 2);

    rst = 1'b1;
    cyc_in(1'b0, 1'b0, 1'b0);
    chk("mid_rst_score", int'(score), 0);
    chk("mid_rst_tl",    int'(time_left), 0);
    chk("mid_rst_busy",  int'(busy), 0);
    chk("mid_rst_done",  int'(done), 0);
    rst = 1'b0;
    pulses(1, 1'b1, 1'b0);
    chk("idle_hit_ignored", int'(score), 0);
    chk("idle_busy",        int'(busy), 0);

    repeat (2) cyc_in(1'b0, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/score_tracker.md
# score_tracker

Game-round controller and score accumulator feeding the score display stage. It edge-detects player hit/miss inputs during a fixed-length timed round and keeps a clamped score. It presents `score[7:0]` directly to the seven-segment decoder, which shows `score / 5`. It also exports remaining round time and round status for LEDs and the top-level controller.

## Interface
- `TICK_DIV`, 100_000_000: clock cycles per round-timer second (≥2).
- `GAME_SECONDS`, 30: round length in seconds (1–255).
- `SCORE_MAX`, 49: score saturation ceiling (≤255). The default keeps the display at ≤ digit 9.
- `HIT_POINTS`, 1: points added per hit edge.
- `MISS_PENALTY`, 1: points removed per miss edge.

Ports:
- `clk` in 1: the single clock. All state is updated on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: start/restart request, level-sensitive, already synchronized. Acts on its rising edge only.
- `hit` in 1: player hit input, synchronized and debounced. Acts on its rising edge only.
- `miss` in 1: player miss input, synchronized and debounced. Acts on its rising edge only.
- `score` out 8: current score, to the display stage.
- `time_left` out 8: whole seconds remaining in the round.
- `busy` out 1: high while a round is running.
- `done` out 1: high from round end until the next start.

## Operation
- The block registers the previous value of each input (`start`, `hit`, `miss`); these previous-value registers reset to 0. A rising edge is defined as input high AND previous value low.
- States: IDLE, RUN, DONE. The reset state is IDLE.
- IDLE:
  - On a `start` edge: go to RUN; set score=0, time_left=GAME_SECONDS, tick counter=0.
  - `hit`/`miss` edges are ignored.
- RUN:
  - `busy`=1.
  - Tick counter counts 0..TICK_DIV-1. At TICK_DIV-1 it wraps to 0 and time_left decrements.
  - When the wrap occurs with time_left==1: time_left becomes 0, state becomes DONE, `done`=1, `busy`=0.
- Scoring (RUN only), applied per edge as score' = clamp(score + H − M, 0, SCORE_MAX):
  - H = HIT_POINTS if a hit edge is present, else 0.
  - M = MISS_PENALTY if a miss edge is present, else 0.
  - Compute in ≥10-bit signed arithmetic so there is no 8-bit wrap. Simultaneous hit and miss edges net out in a single update.
- `start` edges during RUN are ignored; the round is not restarted.
- DONE:
  - `score` is frozen. `time_left`=0, `done`=1.
  - A `start` edge behaves exactly as from IDLE: go to RUN, clear the score, clear `done`.
- Reset at any time, including mid-round, forces IDLE. Output reset values: score=0, time_left=0, busy=0, done=0. Tick counter=0, previous-value registers=0.
- If `start` is held high through reset release, that counts as an edge on the first clock after reset and starts a round.

## Timing
- Inputs are sampled on each rising `clk`. Every output is a register, with no combinational path from inputs to outputs.
- Edge-to-output latency is 1 cycle: an input first sampled high at edge k updates state/score at edge k, and the new value is visible after edge k.
- Round length: the `start` edge is sampled at edge s; time_left decrements at edges s+TICK_DIV, s+2·TICK_DIV, …
- Round end: `done` rises and `busy` falls at edge s+GAME_SECONDS·TICK_DIV.
- A hit/miss edge sampled on the final RUN edge (the one that enters DONE) is still scored.
- Further edges require the input to return low for at least 1 cycle. A held-high input scores only once.

## Test plan
- **Reset values:** assert `rst` for 2 cycles with all inputs high → score=0, time_left=0, busy=0, done=0. Release with `start` still high → busy=1 and time_left=30 one cycle later.
- **Timed round** (TICK_DIV=4, GAME_SECONDS=3): `start` pulse at edge s → time_left reads 2 at s+4, 1 at s+8, 0 at s+12. At s+12, done=1 and busy=0.
- **Scoring and display:** 12 separate `hit` pulses, each 1 high / 1 low cycle → score=12, which the display decodes as digit 2. `hit` held high 10 cycles → score rises by 1 only.
- **Clamps:** 60 hit pulses → score saturates at 49. Then 55 miss pulses → score floors at 0 and never shows 255. Simultaneous hit+miss edge at score=5 → score stays 5.
- **Restart and ignore:** `start` during RUN → no change to time_left or score. After DONE with score=7, `start` → score=0, done=0, busy=1, time_left=GAME_SECONDS. Hit edges in IDLE/DONE → no score change.
- **Mid-round reset:** `rst` at score=20, time_left=2 → all outputs 0 and state IDLE on the next edge. A subsequent hit pulse → score stays 0.
